bp_be_fe_queue_rolly: RTL and testbench
=======================================

# bp_be_fe_queue_rolly

Checkpointed instruction queue between the front end and the BE scheduler. It buffers fetch/exception packets from the FE and presents the oldest unissued packet to the scheduler. Issued packets are held until the commit stage retires them. The scheduler's clear, roll and dequeue controls act directly on three internal pointers: write, speculative read and commit.

## Interface
Parameters:
- width_p, default 64, width in bits of one queue packet (`bp_fe_queue_s`).
- els_p, default 8, number of entries; must be a power of two, ≥2.
- ptr_width_lp, localparam = $clog2(els_p)+1, pointer width including the wrap bit.

Ports:
- clk_i  input  1  clock; all state updates on posedge.
- reset_n_i  input  1  synchronous, active-low reset.
- data_i  input  width_p  packet from FE.
- v_i  input  1  enqueue valid.
- ready_o  output  1  queue can accept; valid/ready handshake.
- data_o  output  width_p  packet at the read pointer.
- v_o  output  1  data_o holds an unissued packet.
- yumi_i  input  1  scheduler consumes data_o this cycle.
- clr_v_i  input  1  discard all unissued packets.
- roll_v_i  input  1  rewind the read pointer to the commit pointer (replay).
- deq_v_i  input  1  retire the oldest issued packet.
- empty_o  output  1  no packets held at all (wptr == cptr).

## Operation
- Storage: els_p × width_p array, one write port and one asynchronous read port. The array is not reset.
- Pointers: wptr, rptr, cptr, each ptr_width_lp bits. The low bits index the array; the MSB is the wrap bit. Arithmetic is modulo 2^ptr_width_lp.
- Invariant: cptr ≤ rptr ≤ wptr in ring order, and wptr − cptr ≤ els_p.
- Status signals:
  - full = (wptr − cptr == els_p), i.e. low bits equal and wrap bits differ.
  - ready_o = ~full.
  - v_o = (rptr != wptr).
  - empty_o = (wptr == cptr).
  - data_o = mem[rptr[low]].
- Enqueue fires when enq = v_i & ready_o & ~clr_v_i. It writes mem[wptr[low]] = data_i.
- Next-state equations, evaluated in this order within one cycle:
  - cptr_n = cptr + (deq_v_i & (cptr != rptr)).
  - rptr_n = roll_v_i ? cptr_n : rptr + (yumi_i & v_o).
  - wptr_n = clr_v_i ? rptr_n : wptr + enq.
- Simultaneous events:
  - roll + yumi: yumi is ignored.
  - roll + deq: rptr lands on the post-dequeue commit pointer.
  - clr + roll: the queue becomes fully empty (all three pointers equal).
  - clr + v_i: the incoming packet is dropped; ready_o is not gated by clr.
  - yumi + deq: both apply.
- Illegal requests are ignored with no state change:
  - deq_v_i while cptr == rptr.
  - yumi_i while ~v_o.
  - Simulation assertions flag both.
- Full queue: ready_o=0; v_i is ignored until a deq frees an entry.
- Wrap-around: pointers roll past 2^ptr_width_lp−1 to 0 with no special handling.

## Timing
- Reset (reset_n_i=0 at a posedge): wptr=rptr=cptr=0. Outputs from the next cycle: v_o=0, ready_o=1, empty_o=1. data_o is don't-care.
- Reset mid-operation drops every entry, including unissued, issued and uncommitted ones.
- Enqueue to v_o latency: 1 cycle. There is no same-cycle bypass, so an empty queue with v_i=1 still shows v_o=0 in that cycle.
- yumi_i → next entry appears on data_o in the next cycle.
- deq_v_i → ready_o can rise in the next cycle.
- roll_v_i / clr_v_i take effect at the edge; outputs reflect the new pointers in the next cycle.
- All outputs are combinational from registered state only. There is no input-to-output combinational path.

## Test plan
- Reset, then fill els_p=4 with A,B,C,D at 1/cycle:
  - ready_o=0 after D; a 5th v_i is ignored.
  - yumi ×4 returns A..D in order.
  - v_o=0 afterwards, and ready_o stays 0 until the first deq.
- Enqueue A,B,C; yumi A,B; deq A; then roll:
  - Next cycle data_o=B and v_o=1.
  - yumi B, C returns B, then C.
- Enqueue A,B,C; yumi A; clr:
  - v_o=0, while empty_o=0 (A is still uncommitted).
  - deq A → empty_o=1.
- Same-cycle clr+roll with v_i=1 after partial issue:
  - All pointers equal, empty_o=1, v_o=0.
  - The incoming packet is not stored.
- Stream 3×els_p packets with yumi+deq each cycle: order is preserved across two pointer wraps, with no spurious full or empty.
- Illegal stimulus: deq with nothing issued, and yumi with v_o=0.
  - Pointers are unchanged.
  - The assertion fires in sim.

Source files
------------

// File: rtl/bp_be_fe_queue_rolly.sv
// bp_be_fe_queue_rolly
// Checkpointed instruction queue between the front end and the BE scheduler.
// Packets are written at wptr, presented to the scheduler at rptr (speculative
// read), and retired at cptr (commit). Issued packets remain resident between
// cptr and rptr, so a roll can replay them. A clr discards everything that has
// not yet been issued.
module bp_be_fe_queue_rolly #(
   parameter  int width_p      = 64,
   parameter  int els_p        = 8,
   localparam int ptr_width_lp = $clog2(els_p) + 1
) (
   input  logic               clk_i,
   input  logic               reset_n_i,

   input  logic [width_p-1:0] data_i,
   input  logic               v_i,
   output logic               ready_o,

   output logic [width_p-1:0] data_o,
   output logic               v_o,
   input  logic               yumi_i,

   input  logic               clr_v_i,
   input  logic               roll_v_i,
   input  logic               deq_v_i,

   output logic               empty_o
);

   // The low bits of each pointer index the array; the MSB is the wrap bit
   // that tells a full ring apart from an empty one.
   localparam int idx_width_lp = ptr_width_lp - 1;

   typedef logic [ptr_width_lp-1:0] ptr_t;
   typedef logic [idx_width_lp-1:0] idx_t;

   logic [width_p-1:0] mem_q [els_p];

   ptr_t wptr_q, wptr_d;
   ptr_t rptr_q, rptr_d;
   ptr_t cptr_q, cptr_d;

   logic full;
   logic enq;
   logic deq_fire;
   logic yumi_fire;

   // Status flags are decoded from registered pointers only, so no input ever
   // reaches an output combinationally.
   assign full = (wptr_q[idx_width_lp-1:0] == cptr_q[idx_width_lp-1:0])
              && (wptr_q[idx_width_lp]     != cptr_q[idx_width_lp]);

   assign ready_o = ~full;
   assign v_o     = (rptr_q != wptr_q);
   assign empty_o = (wptr_q == cptr_q);
   assign data_o  = mem_q[idx_t'(rptr_q[idx_width_lp-1:0])];

   // A clr drops the incoming packet, but ready_o deliberately ignores clr so
   // the FE handshake never depends on a same-cycle scheduler input.
   assign enq       = v_i & ready_o & ~clr_v_i;
   // Illegal requests (deq with nothing issued, yumi with nothing to issue)
   // are masked here so they leave the pointers untouched.
   assign deq_fire  = deq_v_i & (cptr_q != rptr_q);
   assign yumi_fire = yumi_i & v_o;

   // Pointer next-state: commit first, then read (roll sees the post-dequeue
   // commit pointer), then write (clr sees the post-roll read pointer).
   always_comb begin
      cptr_d = cptr_q;
      rptr_d = rptr_q;
      wptr_d = wptr_q;

      cptr_d = cptr_q + ptr_t'(deq_fire);

      if (roll_v_i) begin
         rptr_d = cptr_d;
      end else begin
         rptr_d = rptr_q + ptr_t'(yumi_fire);
      end

      if (clr_v_i) begin
         wptr_d = rptr_d;
      end else begin
         wptr_d = wptr_q + ptr_t'(enq);
      end
   end

   // Pointer registers with synchronous active-low reset; a reset discards
   // every packet regardless of issue or commit state.
   always_ff @(posedge clk_i) begin
      if (!reset_n_i) begin
         wptr_q <= '0;
         rptr_q <= '0;
         cptr_q <= '0;
      end else begin
         // NOTE: non-blocking assignments keep every flop sampling the
         // pre-edge values, independent of statement order.
         wptr_q <= wptr_d;
         rptr_q <= rptr_d;
         cptr_q <= cptr_d;
      end
   end

   // Packet storage write port.
   always_ff @(posedge clk_i) begin
      // NOTE: the array has no reset; entries are only read once a pointer
      // has moved past a written slot, so stale contents are never observed.
      if (enq) begin
         mem_q[idx_t'(wptr_q[idx_width_lp-1:0])] <= data_i;
      end
   end

   // Flag illegal scheduler requests; the datapath already ignores them.
   always_ff @(posedge clk_i) begin
      if (reset_n_i) begin
         assert (!(deq_v_i && (cptr_q == rptr_q)))
            else $warning("bp_be_fe_queue_rolly: deq_v_i with no issued packet");
         assert (!(yumi_i && !v_o))
            else $warning("bp_be_fe_queue_rolly: yumi_i while v_o is low");
      end
   end

endmodule

// File: tb/tb_bp_be_fe_queue_rolly.sv
// Self-checking bench for bp_be_fe_queue_rolly (els_p=4, width_p=16).
// A queue-based reference model (unissued and issued packet lists) predicts
// every output after each cycle; a hand-computed vector table and short
// hand-written sequences cover the fill/drain, roll, clr and wrap cases.
module tb_bp_be_fe_queue_rolly;

   localparam int W   = 16;
   localparam int ELS = 4;

   logic         clk = 1'b0;
   logic         reset_n;
   logic [W-1:0] data_i;
   logic         v_i;
   logic         ready_o;
   logic [W-1:0] data_o;
   logic         v_o;
   logic         yumi;
   logic         clr;
   logic         roll;
   logic         deq;
   logic         empty_o;

   int n_checks = 0;
   int n_fail   = 0;

   // Reference model: pend = enqueued but not yet issued, iss = issued but
   // not yet committed. Both are oldest-first.
   logic [W-1:0] pend [$];
   logic [W-1:0] iss  [$];

   bp_be_fe_queue_rolly #(.width_p(W), .els_p(ELS)) dut (
      .clk_i     (clk),
      .reset_n_i (reset_n),
      .data_i    (data_i),
      .v_i       (v_i),
      .ready_o   (ready_o),
      .data_o    (data_o),
      .v_o       (v_o),
      .yumi_i    (yumi),
      .clr_v_i   (clr),
      .roll_v_i  (roll),
      .deq_v_i   (deq),
      .empty_o   (empty_o)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Compare all outputs against the reference model.
   task automatic check_model(input string tag);
      check({tag, ".v_o"},     32'(v_o),     32'(pend.size() != 0));
      check({tag, ".ready_o"}, 32'(ready_o), 32'((pend.size() + iss.size()) < ELS));
      check({tag, ".empty_o"}, 32'(empty_o), 32'((pend.size() + iss.size()) == 0));
      if (pend.size() != 0) check({tag, ".data_o"}, 32'(data_o), 32'(pend[0]));
   endtask

   // Drive one cycle of stimulus, advance the model, then check after the edge.
   task automatic cycle(input string tag, input logic v, input logic [W-1:0] d,
                        input logic y, input logic dq, input logic c, input logic r);
      bit full_m;
      bit v_m;
      v_i = v; data_i = d; yumi = y; deq = dq; clr = c; roll = r;
      full_m = (pend.size() + iss.size()) == ELS;
      v_m    = pend.size() != 0;
      if (dq && iss.size() != 0) void'(iss.pop_front());
      if (r) begin
         pend = {iss, pend};
         iss.delete();
      end else if (y && v_m) begin
         iss.push_back(pend.pop_front());
      end
      if (c) pend.delete();
      else if (v && !full_m) pend.push_back(d);
      @(posedge clk);
      #1;
      check_model(tag);
   endtask

   task automatic idle(input string tag);
      cycle(tag, 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic do_reset(input string tag);
      reset_n = 1'b0;
      v_i = 1'b0; data_i = '0; yumi = 1'b0; deq = 1'b0; clr = 1'b0; roll = 1'b0;
      @(posedge clk);
      #1;
      reset_n = 1'b1;
      pend.delete();
      iss.delete();
      check({tag, ".rst_v_o"},     32'(v_o),     32'd0);
      check({tag, ".rst_ready_o"}, 32'(ready_o), 32'd1);
      check({tag, ".rst_empty_o"}, 32'(empty_o), 32'd1);
   endtask

   typedef struct {
      logic         v;
      logic [W-1:0] d;
      logic         y;
      logic         dq;
      logic         exp_v;
      logic         exp_ready;
      logic         exp_empty;
      logic         chk_data;
      logic [W-1:0] exp_data;
   } vec_t;

   localparam int NV = 18;
   vec_t tbl [NV];

   initial begin
      // Fill A..D, overflow attempt, drain, commit, illegal requests, re-use.
      tbl[0]  = '{1'b1, 16'h00A1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 16'h00A1};
      tbl[1]  = '{1'b1, 16'h00B2, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 16'h00A1};
      tbl[2]  = '{1'b1, 16'h00C3, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 16'h00A1};
      tbl[3]  = '{1'b1, 16'h00D4, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 16'h00A1};
      tbl[4]  = '{1'b1, 16'h00E5, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 16'h00A1};
      tbl[5]  = '{1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 16'h00B2};
      tbl[6]  = '{1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 16'h00C3};
      tbl[7]  = '{1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 16'h00D4};
      tbl[8]  = '{1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000};
      tbl[9]  = '{1'b1, 16'h00F6, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000};
      tbl[10] = '{1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0000};
      tbl[11] = '{1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0000};
      tbl[12] = '{1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0000};
      tbl[13] = '{1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0000};
      tbl[14] = '{1'b0, 16'h0000, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0000};
      tbl[15] = '{1'b1, 16'h0107, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 16'h0107};
      tbl[16] = '{1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0000};
      tbl[17] = '{1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0000};

      do_reset("t1");
      for (int i = 0; i < NV; i++) begin
         string tag;
         tag = $sformatf("vec%0d", i);
         cycle(tag, tbl[i].v, tbl[i].d, tbl[i].y, tbl[i].dq, 1'b0, 1'b0);
         check({tag, ".tbl_v_o"},     32'(v_o),     32'(tbl[i].exp_v));
         check({tag, ".tbl_ready_o"}, 32'(ready_o), 32'(tbl[i].exp_ready));
         check({tag, ".tbl_empty_o"}, 32'(empty_o), 32'(tbl[i].exp_empty));
         if (tbl[i].chk_data) check({tag, ".tbl_data_o"}, 32'(data_o), 32'(tbl[i].exp_data));
      end

      // Roll replays issued-but-uncommitted packets from the commit pointer.
      do_reset("t2");
      cycle("t2.enqA", 1'b1, 16'h0A0A, 1'b0, 1'b0, 1'b0, 1'b0);
      cycle("t2.enqB", 1'b1, 16'h0B0B, 1'b0, 1'b0, 1'b0, 1'b0);
      cycle("t2.enqC", 1'b1, 16'h0C0C, 1'b0, 1'b0, 1'b0, 1'b0);
      cycle("t2.yumA", 1'b0, '0,       1'b1, 1'b0, 1'b0, 1'b0);
      cycle("t2.yumB", 1'b0, '0,       1'b1, 1'b0, 1'b0, 1'b0);
      cycle("t2.deqA", 1'b0, '0,       1'b0, 1'b1, 1'b0, 1'b0);
      cycle("t2.roll", 1'b0, '0,       1'b0, 1'b0, 1'b0, 1'b1);
      check("t2.roll_v_o",    32'(v_o),    32'd1);
      check("t2.roll_data_o", 32'(data_o), 32'h0B0B);
      cycle("t2.yumB2", 1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b0);
      check("t2.replay_C", 32'(data_o), 32'h0C0C);
      cycle("t2.yumC2", 1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b0);
      check("t2.drained_v_o", 32'(v_o), 32'd0);

      // Roll together with deq and a yumi: yumi ignored, rptr lands on new cptr.
      cycle("t2.rolldeq", 1'b0, '0, 1'b1, 1'b1, 1'b0, 1'b1);
      check("t2.rolldeq_data_o", 32'(data_o), 32'h0C0C);

      // Clr discards unissued packets but keeps the issued one uncommitted.
      do_reset("t3");
      cycle("t3.enqA", 1'b1, 16'h1A1A, 1'b0, 1'b0, 1'b0, 1'b0);
      cycle("t3.enqB", 1'b1, 16'h1B1B, 1'b0, 1'b0, 1'b0, 1'b0);
      cycle("t3.enqC", 1'b1, 16'h1C1C, 1'b0, 1'b0, 1'b0, 1'b0);
      cycle("t3.yumA", 1'b0, '0,       1'b1, 1'b0, 1'b0, 1'b0);
      cycle("t3.clr",  1'b0, '0,       1'b0, 1'b0, 1'b1, 1'b0);
      check("t3.clr_v_o",     32'(v_o),     32'd0);
      check("t3.clr_empty_o", 32'(empty_o), 32'd0);
      cycle("t3.deqA", 1'b0, '0, 1'b0, 1'b1, 1'b0, 1'b0);
      check("t3.deq_empty_o", 32'(empty_o), 32'd1);

      // Clr + roll + v_i after partial issue: queue fully empty, packet dropped.
      do_reset("t4");
      cycle("t4.enqA", 1'b1, 16'h2A2A, 1'b0, 1'b0, 1'b0, 1'b0);
      cycle("t4.enqB", 1'b1, 16'h2B2B, 1'b0, 1'b0, 1'b0, 1'b0);
      cycle("t4.enqC", 1'b1, 16'h2C2C, 1'b0, 1'b0, 1'b0, 1'b0);
      cycle("t4.yumA", 1'b0, '0,       1'b1, 1'b0, 1'b0, 1'b0);
      cycle("t4.clrroll", 1'b1, 16'hDEAD, 1'b0, 1'b0, 1'b1, 1'b1);
      check("t4.cr_empty_o", 32'(empty_o), 32'd1);
      check("t4.cr_v_o",     32'(v_o),     32'd0);
      check("t4.cr_ready_o", 32'(ready_o), 32'd1);
      idle("t4.idle");
      check("t4.dropped_v_o", 32'(v_o), 32'd0);
      cycle("t4.enqY", 1'b1, 16'h3F3F, 1'b0, 1'b0, 1'b0, 1'b0);
      check("t4.new_data_o", 32'(data_o), 32'h3F3F);

      // Stream 3*ELS packets with yumi+deq every cycle across two wraps.
      do_reset("t5");
      cycle("t5.p0", 1'b1, 16'h5000, 1'b0, 1'b0, 1'b0, 1'b0);
      cycle("t5.p1", 1'b1, 16'h5001, 1'b1, 1'b0, 1'b0, 1'b0);
      for (int i = 2; i < 3 * ELS; i++) begin
         cycle($sformatf("t5.p%0d", i), 1'b1, W'(16'h5000 + i), 1'b1, 1'b1, 1'b0, 1'b0);
         check($sformatf("t5.p%0d.ready", i), 32'(ready_o), 32'd1);
         check($sformatf("t5.p%0d.empty", i), 32'(empty_o), 32'd0);
         check($sformatf("t5.p%0d.data", i),  32'(data_o),  32'(16'h5000 + i));
      end
      cycle("t5.drain0", 1'b0, '0, 1'b1, 1'b1, 1'b0, 1'b0);
      cycle("t5.drain1", 1'b0, '0, 1'b0, 1'b1, 1'b0, 1'b0);
      check("t5.final_empty_o", 32'(empty_o), 32'd1);

      // Reset mid-operation drops everything.
      cycle("t6.enq", 1'b1, 16'h6666, 1'b0, 1'b0, 1'b0, 1'b0);
      cycle("t6.yum", 1'b1, 16'h6667, 1'b1, 1'b0, 1'b0, 1'b0);
      do_reset("t6");
      idle("t6.idle");

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
